// File: rtl/phy_tx_serializer.sv
// Two-lane transmit serializer: byte FIFO in, COM training/idle fill, byte pairs
// striped MSB-first across D_0 (older byte) and D_1 (newer byte) in DATA_W-cycle frames.
module phy_tx_serializer #(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] COM        = 8'hBC,
    parameter int                INIT_COM   = 4,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              D_0,
    output logic              D_1,
    output logic              data_frame_out
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = PTR_W + 1;
    localparam int FC_W  = (INIT_COM > 1) ? $clog2(INIT_COM) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam logic [FC_W-1:0]  LAST_FRAME = FC_W'(INIT_COM - 1);

    typedef enum logic [1:0] {IDLE, TRAIN, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0]  sh0_q, sh0_d, sh1_q, sh1_d;
    logic               d0_q, d0_d, d1_q, d1_d, dfo_q, dfo_d;
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [CW-1:0]      count_q, count_d;
    logic               push, pop, load_com, run_load, frame_end;

    assign ready_out      = enable && (state_q != IDLE) && (count_q < CW'(FIFO_DEPTH));
    assign push           = valid_in && ready_out;
    assign rd_nxt         = rd_ptr_q + PTR_W'(1);
    assign frame_end      = (bit_cnt_q == LAST_BIT);
    assign D_0            = d0_q;
    assign D_1            = d1_q;
    assign data_frame_out = dfo_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q + CNT_W'(1);
        frame_cnt_d = frame_cnt_q;
        sh0_d       = sh0_q << 1;
        sh1_d       = sh1_q << 1;
        d0_d        = sh0_q[DATA_W-1];
        d1_d        = sh1_q[DATA_W-1];
        dfo_d       = dfo_q;
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CW'(push);
        load_com    = 1'b0;
        run_load    = 1'b0;
        pop         = 1'b0;

        if (!enable) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            frame_cnt_d = '0;
            sh0_d       = '0;
            sh1_d       = '0;
            d0_d        = 1'b0;
            d1_d        = 1'b0;
            dfo_d       = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d     = TRAIN;
                    frame_cnt_d = '0;
                    load_com    = 1'b1;
                end
                TRAIN: if (frame_end) begin
                    // The load that closes the last training frame is already a RUN load.
                    if (frame_cnt_q == LAST_FRAME) begin
                        state_d  = RUN;
                        run_load = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FC_W'(1);
                        load_com    = 1'b1;
                    end
                end
                RUN: if (frame_end) run_load = 1'b1;
                default: state_d = IDLE;
            endcase

            if (run_load) begin
                if (count_q >= CW'(2)) pop = 1'b1;
                else                   load_com = 1'b1;
            end

            if (load_com) begin
                sh0_d     = COM << 1;
                sh1_d     = COM << 1;
                d0_d      = COM[DATA_W-1];
                d1_d      = COM[DATA_W-1];
                dfo_d     = 1'b0;
                bit_cnt_d = '0;
            end

            if (pop) begin
                sh0_d     = mem_q[rd_ptr_q] << 1;
                sh1_d     = mem_q[rd_nxt] << 1;
                d0_d      = mem_q[rd_ptr_q][DATA_W-1];
                d1_d      = mem_q[rd_nxt][DATA_W-1];
                dfo_d     = 1'b1;
                bit_cnt_d = '0;
                rd_ptr_d  = rd_ptr_q + PTR_W'(2);
                count_d   = count_q + CW'(push) - CW'(2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            sh0_q       <= '0;
            sh1_q       <= '0;
            d0_q        <= 1'b0;
            d1_q        <= 1'b0;
            dfo_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            d0_q        <= d0_d;
            d1_q        <= d1_d;
            dfo_q       <= dfo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Bench for phy_tx_serializer: frame-level queue model checked every cycle,
// directed literal scenarios, then randomized traffic with enable drops and resets.
module tb_phy_tx_serializer;

    logic       clk = 1'b0;
    logic       reset, enable, valid_in;
    logic [7:0] data_in;
    logic       ready_out, D_0, D_1, data_frame_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    phy_tx_serializer #(
        .DATA_W    (8),
        .COM       (8'hBC),
        .INIT_COM  (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .D_0           (D_0),
        .D_1           (D_1),
        .data_frame_out(data_frame_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Model: time since enable picks the frame slot; frames before slot 4 are training,
    // later slots take two bytes from the queue when available, else COM.
    logic       m_en = 1'b0;
    int         m_t = 0;
    logic [7:0] m_q[$];
    logic [7:0] m_f0 = 8'h00, m_f1 = 8'h00;
    logic       m_fdata = 1'b0;
    logic       e_d0 = 1'b0, e_d1 = 1'b0, e_dfo = 1'b0;
    bit         m_push;

    always @(posedge clk) begin
        if (reset || !enable) begin
            m_en = 1'b0;
            m_t  = 0;
            m_q.delete();
            e_d0 = 1'b0; e_d1 = 1'b0; e_dfo = 1'b0;
        end else begin
            m_push = valid_in && m_en && (m_q.size() < 4);
            if (!m_en) begin
                m_en = 1'b1;
                m_t  = 0;
            end else begin
                m_t++;
            end
            if (m_t % 8 == 0) begin
                if (m_t / 8 < 4 || m_q.size() < 2) begin
                    m_f0 = 8'hBC; m_f1 = 8'hBC; m_fdata = 1'b0;
                end else begin
                    m_f0 = m_q.pop_front();
                    m_f1 = m_q.pop_front();
                    m_fdata = 1'b1;
                end
            end
            e_d0  = m_f0[7 - (m_t % 8)];
            e_d1  = m_f1[7 - (m_t % 8)];
            e_dfo = m_fdata;
            if (m_push) m_q.push_back(data_in);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("D_0", 32'(D_0), 32'(e_d0));
            check("D_1", 32'(D_1), 32'(e_d1));
            check("data_frame_out", 32'(data_frame_out), 32'(e_dfo));
            check("ready_out", 32'(ready_out), 32'(enable && m_en && (m_q.size() < 4)));
        end
    end

    initial begin
        logic [7:0] com0, com1, dat0, dat1, nxt;
        int         dens;
        reset = 1'b1; enable = 1'b0; valid_in = 1'b0; data_in = 8'h00;
        @(posedge clk);
        chk_en = 1'b1;
        tick();
        tick();
        check("reset_D_0", 32'(D_0), 32'd0);
        check("reset_ready", 32'(ready_out), 32'd0);
        check("reset_dfo", 32'(data_frame_out), 32'd0);

        // Training pattern and first data frame after exactly four COM frames.
        reset = 1'b0; enable = 1'b1;
        com0 = '0; com1 = '0; dat0 = '0; dat1 = '0;
        for (int k = 0; k < 48; k++) begin
            tick();
            if (k == 0) check("ready_after_enable", 32'(ready_out), 32'd1);
            if (k < 8) begin
                com0 = {com0[6:0], D_0};
                com1 = {com1[6:0], D_1};
            end
            if (k < 32) check("train_dfo", 32'(data_frame_out), 32'd0);
            if (k >= 32 && k < 40) begin
                dat0 = {dat0[6:0], D_0};
                dat1 = {dat1[6:0], D_1};
                check("data_dfo", 32'(data_frame_out), 32'd1);
            end
            if (k == 40) begin
                check("post_data_dfo", 32'(data_frame_out), 32'd0);
                check("post_data_com_msb", 32'(D_0), 32'd1);
            end
            if (k == 9)  begin valid_in = 1'b1; data_in = 8'h5A; end
            if (k == 10) data_in = 8'hC3;
            if (k == 11) valid_in = 1'b0;
        end
        check("com_lane0", 32'(com0), 32'hBC);
        check("com_lane1", 32'(com1), 32'hBC);
        check("data_lane0", 32'(dat0), 32'h5A);
        check("data_lane1", 32'(dat1), 32'hC3);

        // Odd byte waits for its partner.
        valid_in = 1'b1; data_in = 8'h11; tick(); valid_in = 1'b0;
        repeat (20) tick();
        valid_in = 1'b1; data_in = 8'h22; tick(); valid_in = 1'b0;
        repeat (20) tick();

        // Back-pressure: stream 0x01..0x06 with valid held high.
        nxt = 8'h01; valid_in = 1'b1; data_in = nxt;
        for (int k = 0; k < 40 && nxt <= 8'h06; k++) begin
            automatic logic acc = ready_out;
            tick();
            if (acc) begin
                nxt = nxt + 8'h01;
                data_in = nxt;
            end
        end
        valid_in = 1'b0;
        check("backpressure_all_accepted", 32'(nxt), 32'h07);
        repeat (30) tick();

        // Enable drop mid-TRAIN with two bytes buffered, then retrain.
        enable = 1'b0; tick();
        check("drop_D_0", 32'(D_0), 32'd0);
        check("drop_ready", 32'(ready_out), 32'd0);
        enable = 1'b1; repeat (5) tick();
        valid_in = 1'b1; data_in = 8'hA5; tick(); data_in = 8'h3C; tick(); valid_in = 1'b0;
        tick();
        enable = 1'b0; tick();
        check("drop_train_D_1", 32'(D_1), 32'd0);
        check("drop_train_dfo", 32'(data_frame_out), 32'd0);
        enable = 1'b1; repeat (60) tick();

        // Randomized traffic with enable drops and resets.
        dens = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) dens = $urandom_range(95, 5);
            valid_in = ($urandom_range(99) < dens);
            data_in  = 8'($urandom);
            reset    = ($urandom_range(699) == 0);
            if (!enable) enable = ($urandom_range(3) == 0);
            else         enable = ($urandom_range(299) != 0);
            tick();
        end
        reset = 1'b0; valid_in = 1'b0; enable = 1'b1;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
